lcd_cmd_sequencer: RTL and testbench

Table-driven command sequencer for the ST7789V3 LCD path; the parametrised successor of the fixed init-sequence decoder. It holds several command sequences (init, wake, window set) in one packed table. It plays a selected sequence out as DC-tagged packets to the FIFO/serdes with a full ready/valid handshake. Between entries it waits for the serdes to drain, then applies per-entry short/long delays.

---
 rtl/lcd_cmd_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// Table-driven ST7789V3 command sequencer: plays DC-tagged command/argument packets from a packed table.
// Per-entry short/long delays are honoured only when LCD_CMD_SEQ_DELAY_EN is defined.
module lcd_cmd_sequencer #(
  parameter int WORD_WIDTH   = 8,
  parameter int PACKET_WIDTH = WORD_WIDTH + 1,
  parameter int SEQ_DEPTH    = 64,
  parameter int NUM_SEQ      = 4,
  parameter int ARG_BITS     = 3,
  parameter int DLY_WIDTH    = 24,
  parameter logic [DLY_WIDTH-1:0] SHORT_DLY_CYCLES = 24'd150000,
  parameter logic [DLY_WIDTH-1:0] LONG_DLY_CYCLES  = 24'd12000000,
  parameter logic [SEQ_DEPTH*WORD_WIDTH-1:0]         SEQ_TABLE = '0,
  parameter logic [NUM_SEQ*$clog2(SEQ_DEPTH)-1:0]    SEQ_BASE  = '0
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [((NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1)-1:0] seq_sel,
  input  logic                                             upstream_wait,
  input  logic                                             ready,
  output logic                                             valid,
  output logic [PACKET_WIDTH-1:0]                          data,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             err
);
  localparam int AW = $clog2(SEQ_DEPTH);

  typedef logic [AW:0]           addr_t;
  typedef logic [DLY_WIDTH-1:0]  dly_t;
  typedef logic [ARG_BITS-1:0]   cnt_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam addr_t MAX_ADDR = addr_t'(SEQ_DEPTH - 1);
  localparam addr_t ONE      = addr_t'(1);
  localparam addr_t TWO      = addr_t'(2);
  localparam cnt_t  CNT_ONE  = cnt_t'(1);
  localparam dly_t  DLY_ONE  = dly_t'(1);

`ifdef LCD_CMD_SEQ_DELAY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ARGS  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_STALL = 3'd4;

  // Out-of-range reads return zero; callers check the address before acting on the word.
  function automatic word_t word_at(input addr_t a);
    if (a > MAX_ADDR) return '0;
    return SEQ_TABLE[int'(a)*WORD_WIDTH +: WORD_WIDTH];
  endfunction

  function automatic logic is_end(input word_t m);
    return m[7] && m[6];
  endfunction

  logic [2:0] state, state_d;
  addr_t      ent, ent_d, ptr, ptr_d;
  word_t      meta_q, meta_d;
  cnt_t       cnt, cnt_d;
  dly_t       stall_ctr, stall_d;
  logic       done_d, err_d, adv;

  addr_t base_addr, nxt;
  word_t base_meta, nxt_meta;
  cnt_t  n_cur;
  logic  unused_meta;

  always_comb begin
    base_addr = addr_t'(SEQ_BASE[0 +: AW]);
    if (int'(seq_sel) < NUM_SEQ) base_addr = addr_t'(SEQ_BASE[int'(seq_sel)*AW +: AW]);
  end

  assign base_meta   = word_at(base_addr + ONE);
  assign n_cur       = meta_q[ARG_BITS-1:0];
  assign nxt         = ent + TWO + addr_t'(n_cur);
  assign nxt_meta    = word_at(nxt + ONE);
  assign unused_meta = ^{base_meta, nxt_meta, meta_q};

  always_comb begin
    state_d = state;
    ent_d   = ent;
    ptr_d   = ptr;
    meta_d  = meta_q;
    cnt_d   = cnt;
    stall_d = stall_ctr;
    done_d  = 1'b0;
    err_d   = 1'b0;
    adv     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (base_addr + ONE > MAX_ADDR) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (is_end(base_meta)) begin
            done_d = 1'b1;
          end else begin
            ent_d   = base_addr;
            ptr_d   = base_addr;
            meta_d  = base_meta;
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (ready) begin
          if (n_cur == '0) begin
            state_d = S_DRAIN;
          end else if (ptr + TWO > MAX_ADDR) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d   = ptr + TWO;
            cnt_d   = n_cur;
            state_d = S_ARGS;
          end
        end
      end
      S_ARGS: begin
        if (ready) begin
          if (cnt == CNT_ONE) begin
            state_d = S_DRAIN;
          end else if (ptr + ONE > MAX_ADDR) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d = ptr + ONE;
            cnt_d = cnt - CNT_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (!upstream_wait) begin
          if (DLY_EN && meta_q[7]) begin
            stall_d = LONG_DLY_CYCLES;
            state_d = S_STALL;
          end else if (DLY_EN && meta_q[6]) begin
            stall_d = SHORT_DLY_CYCLES;
            state_d = S_STALL;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_STALL: begin
        if (stall_ctr <= DLY_ONE) begin
          stall_d = '0;
          adv     = 1'b1;
        end else begin
          stall_d = stall_ctr - DLY_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entry advance: the next entry's command and meta words must both be addressable.
    if (adv) begin
      if (nxt + ONE > MAX_ADDR) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (is_end(nxt_meta)) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        ent_d   = nxt;
        ptr_d   = nxt;
        meta_d  = nxt_meta;
        state_d = S_CMD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stall_ctr <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      stall_ctr <= stall_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    ent    <= ent_d;
    ptr    <= ptr_d;
    meta_q <= meta_d;
    cnt    <= cnt_d;
  end

  assign valid = (state == S_CMD) || (state == S_ARGS);
  assign busy  = (state != S_IDLE) || done;

  always_comb begin
    data = '0;
    if (valid) data = {state == S_ARGS, word_at(ptr)};
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer; stall expectations follow LCD_CMD_SEQ_DELAY_EN.
module tb_lcd_cmd_sequencer;
`ifdef LCD_CMD_SEQ_DELAY_EN
  localparam int L = 10;
`else
  localparam int L = 0;
`endif

  function automatic logic [511:0] build_table();
    logic [511:0] t;
    t = '0;
    // seq 0 @0: two long-delay commands then end
    t[0*8 +: 8] = 8'h01;  t[1*8 +: 8] = 8'h80;
    t[2*8 +: 8] = 8'h11;  t[3*8 +: 8] = 8'h80;
    t[4*8 +: 8] = 8'h00;  t[5*8 +: 8] = 8'hC0;
    // seq 1 @6: CASET with four args then end
    t[6*8 +: 8] = 8'h2A;  t[7*8 +: 8] = 8'h04;
    t[8*8 +: 8] = 8'h00;  t[9*8 +: 8] = 8'h28;
    t[10*8 +: 8] = 8'h01; t[11*8 +: 8] = 8'h17;
    t[12*8 +: 8] = 8'h00; t[13*8 +: 8] = 8'hC0;
    // seq 3 @20: immediate end marker
    t[20*8 +: 8] = 8'h00; t[21*8 +: 8] = 8'hC0;
    // seq 2 @59: one command, then entry at 61 declaring 4 args (overruns)
    t[59*8 +: 8] = 8'h36; t[60*8 +: 8] = 8'h00;
    t[61*8 +: 8] = 8'h2C; t[62*8 +: 8] = 8'h04;
    t[63*8 +: 8] = 8'h55;
    return t;
  endfunction

  localparam logic [511:0] TABLE = build_table();
  localparam logic [23:0]  BASE  = {6'd20, 6'd59, 6'd6, 6'd0};

  logic       clk = 1'b0;
  logic       rst, start, upstream_wait, ready;
  logic [1:0] seq_sel;
  logic       valid, busy, done, err;
  logic [8:0] data;

  int checks = 0;
  int errors = 0;

  logic [8:0] pk [16];
  int         pc [16];
  int         np, nb, unstable, nz;
  logic       got_done, got_err;

  lcd_cmd_sequencer #(
    .SHORT_DLY_CYCLES(24'd4),
    .LONG_DLY_CYCLES (24'd10),
    .SEQ_TABLE       (TABLE),
    .SEQ_BASE        (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seq_sel      (seq_sel),
    .upstream_wait(upstream_wait),
    .ready        (ready),
    .valid        (valid),
    .data         (data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [1:0] s);
    seq_sel = s;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Records transfers and handshake behaviour until done or the cycle budget runs out.
  task automatic capture(input int maxc, input bit tog, input int start_cycles);
    logic       have_prev;
    logic [8:0] prev_data;
    np = 0; nb = 0; unstable = 0; nz = 0;
    got_done = 1'b0; got_err = 1'b0;
    have_prev = 1'b0; prev_data = '0;
    for (int c = 0; c < maxc; c++) begin
      start = (c < start_cycles);
      if (tog) ready = c[0];
      if (busy) nb++;
      if (have_prev && !(valid === 1'b1 && data === prev_data)) unstable++;
      if (valid !== 1'b1 && data !== 9'h000) nz++;
      if (valid === 1'b1 && ready) begin
        if (np < 16) begin
          pk[np] = data;
          pc[np] = c;
        end
        np++;
      end
      have_prev = (valid === 1'b1) && !ready;
      prev_data = data;
      if (done === 1'b1) begin
        got_done = 1'b1;
        got_err  = err;
        break;
      end
      step();
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seq_sel = '0; upstream_wait = 1'b0; ready = 1'b1;
    step(); step();
    checks++;
    if ({valid, busy, done, err} !== 4'b0000)
      $display("FAIL reset_ctrl got=%b exp=0000", {valid, busy, done, err});
    checks++;
    if (data !== 9'h000) $display("FAIL reset_data got=%h exp=000", data);
    if ({valid, busy, done, err} !== 4'b0000) errors++;
    if (data !== 9'h000) errors++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_delay_seq();
    ready = 1'b1; upstream_wait = 1'b0;
    start_seq(2'd0);
    capture(200, 1'b0, 0);
    checks++;
    if (!(got_done && !got_err)) begin
      errors++;
      $display("FAIL seq0_done got=%b/%b exp=1/0", got_done, got_err);
    end
    checks++;
    if (np !== 2 || pk[0] !== 9'h001 || pk[1] !== 9'h011) begin
      errors++;
      $display("FAIL seq0_packets got n=%0d %h %h exp n=2 001 011", np, pk[0], pk[1]);
    end
    checks++;
    if (pc[0] !== 0 || pc[1] - pc[0] !== 2 + L) begin
      errors++;
      $display("FAIL seq0_spacing got=%0d,%0d exp=0,%0d", pc[0], pc[1] - pc[0], 2 + L);
    end
    checks++;
    if (nb !== 2 * (2 + L) + 1) begin
      errors++;
      $display("FAIL seq0_busy_len got=%0d exp=%0d", nb, 2 * (2 + L) + 1);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL seq0_after got=%b%b exp=00", busy, done);
    end
  endtask

  task automatic test_caset_handshake();
    logic [8:0] e [5];
    e = '{9'h02A, 9'h100, 9'h128, 9'h101, 9'h117};
    upstream_wait = 1'b0;
    start_seq(2'd1);
    capture(100, 1'b1, 0);
    checks++;
    if (np !== 5) begin
      errors++;
      $display("FAIL caset_count got=%0d exp=5", np);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pk[i] !== e[i]) begin
        errors++;
        $display("FAIL caset_pkt%0d got=%h exp=%h", i, pk[i], e[i]);
      end
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL caset_hold got=%0d exp=0", unstable);
    end
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL caset_idle_data got=%0d exp=0", nz);
    end
    checks++;
    if (!(got_done && !got_err)) begin
      errors++;
      $display("FAIL caset_done got=%b/%b exp=1/0", got_done, got_err);
    end
    step();
  endtask

  task automatic test_upstream_wait();
    logic [8:0] e [5];
    e = '{9'h02A, 9'h100, 9'h128, 9'h101, 9'h117};
    ready = 1'b1; upstream_wait = 1'b1;
    start_seq(2'd1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid !== 1'b1 || data !== e[i]) begin
        errors++;
        $display("FAIL b2b_pkt%0d got=%b/%h exp=1/%h", i, valid, data, e[i]);
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({valid, done, busy} !== 3'b001) begin
        errors++;
        $display("FAIL drain_hold%0d got=%b exp=001", i, {valid, done, busy});
      end
      step();
    end
    upstream_wait = 1'b0;
    step();
    checks++;
    if ({done, err, valid} !== 3'b100) begin
      errors++;
      $display("FAIL drain_release got=%b exp=100", {done, err, valid});
    end
    step();
  endtask

  task automatic test_end_marker();
    start_seq(2'd3);
    checks++;
    if ({done, err, valid, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL endmark_now got=%b exp=1001", {done, err, valid, busy});
    end
    step();
    checks++;
    if ({done, valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL endmark_after got=%b exp=000", {done, valid, busy});
    end
  endtask

  task automatic test_reset_then_overrun();
    ready = 1'b1; upstream_wait = 1'b0;
    start_seq(2'd0);
    step(); step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({valid, busy, done, err} !== 4'b0000 || data !== 9'h000) begin
      errors++;
      $display("FAIL midrun_rst got=%b/%h exp=0000/000", {valid, busy, done, err}, data);
    end
    step();
    checks++;
    if ({done, err} !== 2'b00) begin
      errors++;
      $display("FAIL rst_nodone got=%b exp=00", {done, err});
    end
    start_seq(2'd2);
    seq_sel = 2'd0;
    capture(100, 1'b0, 2);
    checks++;
    if (np !== 3 || pk[0] !== 9'h036 || pk[1] !== 9'h02C || pk[2] !== 9'h155) begin
      errors++;
      $display("FAIL seq2_packets got n=%0d %h %h %h exp n=3 036 02C 155", np, pk[0], pk[1], pk[2]);
    end
    checks++;
    if (!(got_done && got_err)) begin
      errors++;
      $display("FAIL overrun_flags got=%b/%b exp=1/1", got_done, got_err);
    end
    checks++;
    if (nb !== 5 || valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_len got=%0d/%b exp=5/0", nb, valid);
    end
    step();
    checks++;
    if ({done, err, busy, valid} !== 4'b0000) begin
      errors++;
      $display("FAIL overrun_after got=%b exp=0000", {done, err, busy, valid});
    end
  endtask

  initial begin
    test_reset();
    test_delay_seq();
    test_caset_handshake();
    test_upstream_wait();
    test_end_marker();
    test_reset_then_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
